// File: rtl/opcode_encoder.sv
// One-hot to binary opcode encoder with a single-entry output register,
// zero/multi-hot error flags and a saturating, clearable error counter.
module opcode_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      hotselect,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       opCode,
  output logic             err_zero,
  output logic             err_multi,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count
);

  // Handshake: a word moves on a rising edge when valid && ready are both 1.
  // valid never waits on ready; once out_valid is up, opCode/flags stay frozen
  // until out_ready is seen. in_ready is the only combinational output.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             err_zero_q, err_zero_d;
  logic             err_multi_q, err_multi_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       accept;
  logic [3:0] low_idx;
  logic       is_zero;
  logic       is_multi;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (hotselect[i]) low_idx = 4'(i);
    end
  end

  assign is_zero  = (hotselect == 16'h0000);
  assign is_multi = |(hotselect & (hotselect - 16'd1));

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    err_zero_d  = err_zero_q;
    err_multi_d = err_multi_q;
    err_count_d = err_count_q;

    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = low_idx;
      err_zero_d  = is_zero;
      err_multi_d = is_multi;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear has priority over a coincident error accept.
    if (clr_err) begin
      err_count_d = '0;
    end else if (accept && (is_zero || is_multi) && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      opcode_q    <= 4'd0;
      err_zero_q  <= 1'b0;
      err_multi_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      err_zero_q  <= err_zero_d;
      err_multi_q <= err_multi_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opCode    = opcode_q;
  assign err_zero  = err_zero_q;
  assign err_multi = err_multi_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_opcode_encoder.sv
// Directed and random checks of opcode_encoder against a behavioural model
// of the one-hot encode, output hold/drain and saturating error count.
module tb_opcode_encoder;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [15:0]      hotselect;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       opCode;
  logic             err_zero;
  logic             err_multi;
  logic             clr_err;
  logic [CNT_W-1:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic       m_valid;
  logic [3:0] m_op;
  logic       m_zero;
  logic       m_multi;
  int         m_cnt;

  opcode_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .hotselect (hotselect),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .opCode    (opCode),
    .err_zero  (err_zero),
    .err_multi (err_multi),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lowest set bit index computed arithmetically: isolate it, then take log2.
  function automatic int lowest_index(input logic [15:0] h);
    logic [15:0] iso;
    if (h == 16'h0) return 0;
    iso = h & (~h + 16'd1);
    return $clog2(iso);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_op    = 4'd0;
    m_zero  = 1'b0;
    m_multi = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".opCode"},    32'(opCode),    32'(m_op));
    check({tag, ".err_zero"},  32'(err_zero),  32'(m_zero));
    check({tag, ".err_multi"}, 32'(err_multi), 32'(m_multi));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
  endtask

  // Driver: one clock cycle of stimulus, checking in_ready before the edge
  // and every output just after it.
  task automatic step(input string tag, input logic iv, input logic [15:0] hs,
                      input logic ordy, input logic clr);
    logic acc;
    int   ones;
    @(negedge clk);
    in_valid  = iv;
    hotselect = hs;
    out_ready = ordy;
    clr_err   = clr;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
    acc  = iv && (!m_valid || ordy) && rst_n;
    ones = $countones(hs);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_op    = 4'(lowest_index(hs));
        m_zero  = (ones == 0);
        m_multi = (ones > 1);
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (clr) m_cnt = 0;
      else if (acc && ones != 1 && m_cnt < CNT_MAX) m_cnt++;
    end
    check_outputs(tag);
  endtask

  function automatic logic [15:0] rand_error_word();
    logic [15:0] h;
    h = 16'($urandom);
    if ($countones(h) == 1) h = 16'h0;
    return h;
  endfunction

  initial begin
    logic [15:0] h;
    in_valid  = 1'b0;
    hotselect = 16'h0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    rst_n     = 1'b0;
    model_reset();

    // Reset state; in_ready is high during reset but nothing is accepted
    #12;
    check_outputs("reset");
    check("reset.in_ready", 32'(in_ready), 32'd1);
    step("reset_accept", 1'b1, 16'h0004, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sweep of all 16 legal one-hot values
    for (int i = 0; i < 16; i++) step($sformatf("sweep%0d", i), 1'b1, 16'(1 << i), 1'b1, 1'b0);
    step("sweep_drain", 1'b0, 16'h0, 1'b1, 1'b0);
    check("sweep.count_zero", 32'(err_count), 32'd0);

    // Zero and multi-hot errors
    step("err_zero", 1'b1, 16'h0000, 1'b1, 1'b0);
    check("err_zero.op", 32'(opCode), 32'd0);
    step("err_multi", 1'b1, 16'h0014, 1'b1, 1'b0);
    check("err_multi.op", 32'(opCode), 32'd2);
    check("err.count2", 32'(err_count), 32'd2);
    step("err_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Backpressure: held output ignores changing hotselect
    step("bp_accept", 1'b1, 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_hold%0d", i), 1'b1, 16'($urandom), 1'b0, 1'b0);
      check("bp.op8", 32'(opCode), 32'd8);
      check("bp.in_ready0", 32'(in_ready), 32'd0);
    end
    step("bp_drain", 1'b0, 16'h0, 1'b1, 1'b0);
    check("bp.drained", 32'(out_valid), 32'd0);

    // Streaming at full throughput
    step("stream0", 1'b1, 16'h0001, 1'b1, 1'b0);
    check("stream0.op", 32'(opCode), 32'd0);
    step("stream1", 1'b1, 16'h8000, 1'b1, 1'b0);
    check("stream1.op", 32'(opCode), 32'd15);
    check("stream1.valid", 32'(out_valid), 32'd1);
    step("stream2", 1'b1, 16'h0040, 1'b1, 1'b0);
    check("stream2.op", 32'(opCode), 32'd6);
    check("stream2.valid", 32'(out_valid), 32'd1);
    step("stream_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Random traffic with occasional clears
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0, 1: h = 16'(1 << $urandom_range(0, 15));
        2:    h = 16'h0;
        default: h = 16'($urandom);
      endcase
      step("rand", 1'($urandom_range(0, 1)), h, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));
    end

    // Saturation then clear coinciding with an error accept
    step("sat_clear", 1'b0, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step("sat", 1'b1, rand_error_word(), 1'b1, 1'b0);
    check("sat.count255", 32'(err_count), 32'd255);
    step("sat_clr_win", 1'b1, 16'h0000, 1'b1, 1'b1);
    check("sat.clr_wins", 32'(err_count), 32'd0);

    // Async reset mid-transfer, between clock edges
    step("ar_load", 1'b1, 16'h0030, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 1'b1, 16'h0200, 1'b1, 1'b0);
    check("post_reset.op", 32'(opCode), 32'd9);
    step("post_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/opcode_encoder.md
OPCODE_ENCODER -- requirements
Module: opcode_encoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the error counter err_count.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port in_valid, input, 1: hotselect word on hotselect is valid.
REQ-005 Port hotselect, input, 16: one-hot opcode select vector; bit i selects opcode i.
REQ-006 Port in_ready, output, 1: block can accept a word this cycle.
REQ-007 Port out_valid, output, 1: opCode and flags are valid.
REQ-008 Port out_ready, input, 1: downstream accepts the output this cycle.
REQ-009 Port opCode, output, 4: encoded opcode.
REQ-010 Port err_zero, output, 1: the accepted word had no bit set.
REQ-011 Port err_multi, output, 1: the accepted word had two or more bits set.
REQ-012 Port clr_err, input, 1: synchronous clear of err_count.
REQ-013 Port err_count, output, CNT_W: saturating count of accepted words with err_zero or err_multi.

Function
REQ-014 Accept event = in_valid && in_ready on a rising edge.
REQ-015 in_ready = !out_valid || out_ready, combinational; a single output register gives full throughput.
REQ-016 On accept: opCode <= index of the lowest set bit of hotselect; out_valid <= 1 on the next cycle (latency 1 clock).
REQ-017 On accept with hotselect == 0: opCode <= 0, err_zero <= 1, err_multi <= 0.
REQ-018 On accept with more than one bit set: opCode <= lowest set index, err_multi <= 1, err_zero <= 0.
REQ-019 On accept with exactly one bit set: err_zero <= 0, err_multi <= 0.
REQ-020 Output hold: while out_valid && !out_ready, opCode, err_zero, err_multi and out_valid remain stable, and hotselect is ignored.
REQ-021 Drain: on out_valid && out_ready with no new accept, out_valid <= 0; opCode and the flags keep their last values.
REQ-022 Simultaneous drain and accept: the new word replaces the old in the same cycle, and out_valid stays 1.
REQ-023 err_count increments by 1 on each accept with err_zero or err_multi condition.
REQ-024 err_count saturates at 2^CNT_W-1 and does not wrap.
REQ-025 clr_err sets err_count to 0 on the next edge; when clr_err coincides with an error accept, the clear wins (result 0).
REQ-026 The encoding is the exact inverse of the 4-to-16 opcode decoder for every legal one-hot value (16 cases).
REQ-027 No combinational path from hotselect to opCode; only in_ready depends combinationally on out_ready.

Reset
REQ-028 rst_n low asynchronously forces out_valid=0, opCode=0, err_zero=0, err_multi=0 and err_count=0.
REQ-029 During reset, in_ready = 1 (follows REQ-015), but no accept takes effect.
REQ-030 Reset asserted mid-transfer discards the pending output; the first accept after rst_n rises is processed normally.
REQ-031 rst_n deassertion is synchronised externally; the block adds no reset synchroniser.

Verification
REQ-032 Sweep: hotselect=1<<i for i=0..15, out_ready=1 -> opCode=i one cycle later, flags 0, err_count stays 0.
REQ-033 Errors: hotselect=16'h0000, then 16'h0014 -> {opCode=0, err_zero=1}, then {opCode=2, err_multi=1}; err_count=2.
REQ-034 Backpressure: accept 16'h0100 with out_ready=0 for 3 cycles while hotselect changes -> opCode holds 8, in_ready=0; out_ready=1 -> drain.
REQ-035 Streaming: in_valid=1 and out_ready=1 every cycle with 16'h0001, 16'h8000, 16'h0040 -> outputs 0, 15, 6 on consecutive cycles, out_valid continuously 1.
REQ-036 Saturation and clear: CNT_W=8, 300 error words -> err_count=255; clr_err together with an error accept -> err_count=0.
REQ-037 Async reset: assert rst_n=0 between clock edges while out_valid=1 -> outputs go to 0 immediately, with no clock edge required.
